// File: rtl/mem_obi_pkg.sv
// Shared types for the CPU memory port to OBI bridge.
// Holds the FSM state encoding, the request routing decision and the error counter width.
package mem_obi_pkg;

   localparam int ERR_CNT_W = 8;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

   typedef enum logic [1:0] {ROUTE_INSTR, ROUTE_DATA, ROUTE_ILLEGAL} route_e;

endpackage

// File: rtl/mem_obi_err_log.sv
// Error bookkeeping for the bridge.
// Keeps a sticky flag, the address of the first error since the last clear, and a saturating count.
module mem_obi_err_log
   import mem_obi_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set,
   input  logic                 clr,
   input  logic [ADDR_W-1:0]    addr,
   output logic                 err,
   output logic [ADDR_W-1:0]    err_addr,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err      <= 1'b0;
         err_addr <= '0;
         err_cnt  <= '0;
      end else begin
         // A new error beats a simultaneous clear.
         if (set)      err <= 1'b1;
         else if (clr) err <= 1'b0;

         if (set && (!err || clr)) err_addr <= addr;
         else if (clr)             err_addr <= '0;

         if (set && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_obi_bridge.sv
// Bridge from the core's valid/ready memory port to separate instruction and data OBI masters.
// Handles routing, the req/gnt/rvalid handshake, bus errors, timeouts and late responses.
module mem_obi_bridge
   import mem_obi_pkg::*;
#(
   parameter int                 ADDR_W       = 32,
   parameter int                 DATA_W       = 32,
   parameter logic [ADDR_W-1:0]  IREGION_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0]  IREGION_MASK = 32'hFFFF_F000,
   parameter int                 TIMEOUT      = 256,
   parameter logic [DATA_W-1:0]  ERR_RDATA    = 32'hDEAD_BEEF
) (
   input  logic                 clk,
   input  logic                 rst,
   // core side
   input  logic                 mem_valid,
   input  logic                 mem_instr,
   input  logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W/8-1:0]  mem_wstrb,
   output logic                 mem_ready,
   output logic [DATA_W-1:0]    mem_rdata,
   // instruction port
   output logic                 instr_req_o,
   input  logic                 instr_gnt_i,
   input  logic                 instr_rvalid_i,
   output logic [ADDR_W-1:0]    instr_addr_o,
   input  logic [DATA_W-1:0]    instr_rdata_i,
   input  logic                 instr_err_i,
   // data port
   output logic                 data_req_o,
   input  logic                 data_gnt_i,
   input  logic                 data_rvalid_i,
   output logic [ADDR_W-1:0]    data_addr_o,
   output logic                 data_we_o,
   output logic [DATA_W/8-1:0]  data_be_o,
   output logic [DATA_W-1:0]    data_wdata_o,
   input  logic [DATA_W-1:0]    data_rdata_i,
   input  logic                 data_err_i,
   // error log
   input  logic                 err_clr_i,
   output logic                 err_o,
   output logic [ADDR_W-1:0]    err_addr_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int BE_W = DATA_W / 8;
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e              state_q, state_d;
   route_e              route_q, route_d, route_new;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic                we_q;
   logic                req_q, req_d;
   logic [TO_W-1:0]     to_cnt_q;
   logic [1:0]          stale_q, stale_d;   // bit 0 instr, bit 1 data
   logic [DATA_W-1:0]   rdata_d;
   logic                accept, err_set;
   logic [ADDR_W-1:0]   err_addr_d;
   logic                port_q, port_d;
   logic                sel_gnt, sel_rvalid, sel_err, timeout_hit;
   logic [DATA_W-1:0]   sel_rdata;

   always_comb begin
      route_new = ROUTE_DATA;
      if (mem_wstrb != '0) begin
         if (mem_instr) route_new = ROUTE_ILLEGAL;
      end else if (mem_instr || ((mem_addr & IREGION_MASK) == IREGION_BASE)) begin
         route_new = ROUTE_INSTR;
      end
   end

   assign port_q      = (route_q == ROUTE_DATA);
   assign sel_gnt     = port_q ? data_gnt_i    : instr_gnt_i;
   assign sel_rvalid  = port_q ? data_rvalid_i : instr_rvalid_i;
   assign sel_err     = port_q ? data_err_i    : instr_err_i;
   assign sel_rdata   = port_q ? data_rdata_i  : instr_rdata_i;
   assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_LIMIT);

   always_comb begin
      state_d    = state_q;
      route_d    = route_q;
      rdata_d    = mem_rdata;
      err_set    = 1'b0;
      err_addr_d = addr_q;
      accept     = 1'b0;
      stale_d    = stale_q;
      // A response owed to an aborted transaction is swallowed here, whatever the state.
      if (stale_q[0] && instr_rvalid_i) stale_d[0] = 1'b0;
      if (stale_q[1] && data_rvalid_i)  stale_d[1] = 1'b0;

      unique case (state_q)
         IDLE: begin
            // mem_ready high means the core still holds the request just completed.
            if (mem_valid && !mem_ready) begin
               accept  = 1'b1;
               route_d = route_new;
               if (route_new == ROUTE_ILLEGAL) begin
                  state_d    = DONE;
                  rdata_d    = ERR_RDATA;
                  err_set    = 1'b1;
                  err_addr_d = mem_addr;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (timeout_hit) begin
               state_d = DONE;
               rdata_d = ERR_RDATA;
               err_set = 1'b1;
               if (req_q && sel_gnt) stale_d[port_q] = 1'b1;
            end else if (req_q && sel_gnt) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (sel_rvalid) begin
               state_d = DONE;
               err_set = sel_err;
               if (sel_err)   rdata_d = ERR_RDATA;
               else if (we_q) rdata_d = '0;
               else           rdata_d = sel_rdata;
            end else if (timeout_hit) begin
               state_d          = DONE;
               rdata_d          = ERR_RDATA;
               err_set          = 1'b1;
               stale_d[port_q]  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      port_d = (route_d == ROUTE_DATA);
      req_d  = (state_d == REQ) && !stale_d[port_d];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         route_q   <= ROUTE_INSTR;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         req_q     <= 1'b0;
         to_cnt_q  <= '0;
         stale_q   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state_q   <= state_d;
         route_q   <= route_d;
         req_q     <= req_d;
         stale_q   <= stale_d;
         mem_ready <= (state_q == DONE);
         mem_rdata <= rdata_d;
         if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            we_q    <= |mem_wstrb;
            be_q    <= (|mem_wstrb) ? mem_wstrb : '1;
         end
         if (accept)
            to_cnt_q <= '0;
         else if (((state_q == REQ) || (state_q == RESP)) && (to_cnt_q != TO_LIMIT))
            to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   assign instr_req_o  = req_q && (route_q == ROUTE_INSTR);
   assign data_req_o   = req_q && (route_q == ROUTE_DATA);
   assign instr_addr_o = addr_q;
   assign data_addr_o  = addr_q;
   assign data_we_o    = we_q;
   assign data_be_o    = be_q;
   assign data_wdata_o = wdata_q;

   mem_obi_err_log #(.ADDR_W(ADDR_W)) u_err_log (
      .clk      (clk),
      .rst      (rst),
      .set      (err_set),
      .clr      (err_clr_i),
      .addr     (err_addr_d),
      .err      (err_o),
      .err_addr (err_addr_o),
      .err_cnt  (err_cnt_o)
   );

endmodule

// File: tb/tb_mem_obi_bridge.sv
// Directed bench for mem_obi_bridge: routing, latency, errors, timeout with late response, reset.
module tb_mem_obi_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_valid = 0, mem_instr = 0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        instr_req_o, instr_gnt_i = 0, instr_rvalid_i = 0, instr_err_i = 0;
   logic [31:0] instr_addr_o, instr_rdata_i = '0;
   logic        data_req_o, data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0, data_we_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0;
   logic [3:0]  data_be_o;
   logic        err_clr_i = 0, err_o;
   logic [31:0] err_addr_o;
   logic [7:0]  err_cnt_o;

   int n_chk = 0, n_pass = 0;
   int instr_req_cyc = 0, data_req_cyc = 0, ready_cyc = 0;
   int cyc, i0, d0, r0;

   mem_obi_bridge #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
      .err_clr_i(err_clr_i), .err_o(err_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (instr_req_o) instr_req_cyc++;
      if (data_req_o)  data_req_cyc++;
      if (mem_ready)   ready_cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      i0 = instr_req_cyc; d0 = data_req_cyc; r0 = ready_cyc;
   endtask

   task automatic wait_ready(inout int c);
      while (!mem_ready && c < 64) begin
         tick();
         c++;
      end
      chk("ready_seen", mem_ready, 1'b1);
   endtask

   // port: 0 instr, 1 data. gdly: cycles of req before gnt.
   task automatic do_txn(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int port, input int gdly,
                         input logic [31:0] rdata, input logic err, output int c);
      mem_valid = 1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
      c = 0;
      tick(); c++;
      repeat (gdly) begin tick(); c++; end
      if (port == 0) instr_gnt_i = 1; else data_gnt_i = 1;
      tick(); c++;
      instr_gnt_i = 0; data_gnt_i = 0;
      if (port == 0) begin instr_rvalid_i = 1; instr_rdata_i = rdata; instr_err_i = err; end
      else           begin data_rvalid_i  = 1; data_rdata_i  = rdata; data_err_i  = err; end
      tick(); c++;
      instr_rvalid_i = 0; data_rvalid_i = 0; instr_err_i = 0; data_err_i = 0;
      wait_ready(c);
   endtask

   task automatic end_txn();
      mem_valid = 0; mem_instr = 0; mem_wstrb = '0;
      tick();
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_ready", mem_ready, 0);
      chk("rst_rdata", mem_rdata, 0);
      chk("rst_reqs", {instr_req_o, data_req_o, err_o}, 0);
      chk("rst_errcnt", err_cnt_o, 0);
      rst = 1;
      tick();

      // instruction-region read, best-case latency
      snap();
      do_txn(0, 32'h0000_0100, '0, 4'b0000, 0, 0, 32'h1234_5678, 0, cyc);
      chk("rd_latency", cyc, 4);
      chk("rd_rdata", mem_rdata, 32'h1234_5678);
      chk("rd_addr", instr_addr_o, 32'h0000_0100);
      end_txn();
      chk("rd_ready_pulse", ready_cyc - r0, 1);
      chk("rd_no_data_req", data_req_cyc - d0, 0);
      chk("rd_instr_req", instr_req_cyc - i0, 1);

      // data write, grant held off
      snap();
      do_txn(0, 32'h2000_0004, 32'hAABB_CCDD, 4'b0011, 1, 4, 32'h5555_5555, 0, cyc);
      chk("wr_latency", cyc, 8);
      chk("wr_we", data_we_o, 1);
      chk("wr_be", data_be_o, 4'b0011);
      chk("wr_wdata", data_wdata_o, 32'hAABB_CCDD);
      chk("wr_addr", data_addr_o, 32'h2000_0004);
      chk("wr_rdata_zero", mem_rdata, 0);
      end_txn();
      chk("wr_req_cycles", data_req_cyc - d0, 5);
      chk("wr_ready_pulse", ready_cyc - r0, 1);
      chk("wr_no_instr_req", instr_req_cyc - i0, 0);

      // bus errors
      do_txn(0, 32'h2000_0000, '0, 4'b0000, 1, 0, 32'h0000_1111, 1, cyc);
      chk("err1_rdata", mem_rdata, 32'hDEAD_BEEF);
      chk("err1_flag", err_o, 1);
      chk("err1_addr", err_addr_o, 32'h2000_0000);
      chk("err1_cnt", err_cnt_o, 1);
      end_txn();
      do_txn(0, 32'h2000_0008, '0, 4'b0000, 1, 1, 32'h0000_2222, 1, cyc);
      chk("err2_addr_kept", err_addr_o, 32'h2000_0000);
      chk("err2_cnt", err_cnt_o, 2);
      end_txn();
      err_clr_i = 1; tick(); err_clr_i = 0;
      chk("clr_flag", err_o, 0);
      chk("clr_addr", err_addr_o, 0);
      chk("clr_cnt_kept", err_cnt_o, 2);

      // timeout in RESP, then late response discarded
      mem_valid = 1; mem_addr = 32'h2000_0010; mem_wstrb = '0;
      cyc = 0;
      tick(); cyc++;
      chk("to_req", data_req_o, 1);
      data_gnt_i = 1;
      tick(); cyc++;
      data_gnt_i = 0;
      wait_ready(cyc);
      chk("to_latency", cyc, 18);
      chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
      chk("to_err", err_o, 1);
      chk("to_err_addr", err_addr_o, 32'h2000_0010);
      chk("to_cnt", err_cnt_o, 3);
      end_txn();

      snap();
      mem_valid = 1; mem_addr = 32'h2000_0020;
      tick();
      chk("stale_wait1", data_req_o, 0);
      tick();
      chk("stale_wait2", data_req_o, 0);
      data_rvalid_i = 1; data_rdata_i = 32'hBAD0_BAD0;
      tick();
      data_rvalid_i = 0;
      chk("stale_req_up", data_req_o, 1);
      chk("stale_no_ready", mem_ready, 0);
      data_gnt_i = 1;
      tick();
      data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hCAFE_F00D;
      tick();
      data_rvalid_i = 0;
      cyc = 0;
      wait_ready(cyc);
      chk("stale_rdata", mem_rdata, 32'hCAFE_F00D);
      chk("stale_cnt", err_cnt_o, 3);
      end_txn();
      chk("stale_one_ready", ready_cyc - r0, 1);

      // illegal instruction write
      err_clr_i = 1; tick(); err_clr_i = 0;
      snap();
      mem_valid = 1; mem_instr = 1; mem_addr = 32'h0000_0040; mem_wstrb = 4'hF;
      tick();
      chk("ill_not_yet", mem_ready, 0);
      tick();
      chk("ill_ready", mem_ready, 1);
      chk("ill_err", err_o, 1);
      chk("ill_err_addr", err_addr_o, 32'h0000_0040);
      chk("ill_cnt", err_cnt_o, 4);
      chk("ill_rdata", mem_rdata, 32'hDEAD_BEEF);
      end_txn();
      chk("ill_no_req", (instr_req_cyc - i0) + (data_req_cyc - d0), 0);

      // reset while in RESP
      snap();
      mem_valid = 1; mem_addr = 32'h2000_0030;
      tick();
      data_gnt_i = 1;
      tick();
      data_gnt_i = 0;
      rst = 0;
      #1;
      chk("rr_ready", mem_ready, 0);
      chk("rr_outs", {instr_req_o, data_req_o, data_we_o, err_o}, 0);
      chk("rr_rdata", mem_rdata, 0);
      chk("rr_addr", data_addr_o, 0);
      chk("rr_cnt", err_cnt_o, 0);
      mem_valid = 0;
      repeat (3) tick();
      rst = 1;
      tick();
      chk("rr_no_ready", ready_cyc - r0, 0);
      do_txn(0, 32'h0000_0200, '0, 4'b0000, 0, 0, 32'h55AA_33CC, 0, cyc);
      chk("rr_next_latency", cyc, 4);
      chk("rr_next_rdata", mem_rdata, 32'h55AA_33CC);
      end_txn();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_obi_bridge.md
Name: mem_obi_bridge

Overview:
- Parametrised bridge from the processor's valid/ready memory port (mem_valid/mem_instr/mem_ready) to two OBI-style master ports: instruction (read-only) and data (read/write).
- Adds what the previous bridge lacked:
  - a full req/gnt/rvalid handshake with registered outputs
  - a configurable instruction region
  - a bus-error path and transaction timeout
  - discarding of late responses
- Sits between the CPU core and the interconnect in the processor block.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- IREGION_BASE, 32'h0000_0000, base of the region whose reads go to the instruction port.
- IREGION_MASK, 32'hFFFF_F000, address bits compared against IREGION_BASE.
- TIMEOUT, 256, cycles allowed in REQ+RESP before abort; a value of 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on error or timeout.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request valid
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  ADDR_W  request address
- mem_wdata  in  DATA_W  write data
- mem_wstrb  in  DATA_W/8  write strobes; all-zero means read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  read data, valid with mem_ready
- instr_req_o  out  1  instruction port request
- instr_gnt_i  in  1  instruction port grant
- instr_rvalid_i  in  1  instruction port response valid
- instr_addr_o  out  ADDR_W  instruction port address
- instr_rdata_i  in  DATA_W  instruction port read data
- instr_err_i  in  1  instruction port error, qualified by rvalid
- data_req_o, data_gnt_i, data_rvalid_i, data_addr_o, data_rdata_i, data_err_i: data port, same meaning as the instruction port
- data_we_o  out  1  data port write enable
- data_be_o  out  DATA_W/8  data port byte enables
- data_wdata_o  out  DATA_W  data port write data
- err_clr_i  in  1  clears err_o and err_addr_o
- err_o  out  1  sticky error flag
- err_addr_o  out  ADDR_W  address of the first error since last clear
- err_cnt_o  out  8  saturating error/timeout count, cleared only by reset

Behaviour:
- Interface fixed: one clock, clk; reset rst is asynchronous and active-low. On reset, all outputs are 0, mem_rdata is 0, the FSM is IDLE and stale flags are cleared.
- Routing:
  - A read (wstrb==0) with mem_instr=1 or (mem_addr & IREGION_MASK)==IREGION_BASE goes to the instruction port.
  - All other reads and all writes go to the data port.
  - A write with mem_instr=1 is illegal: no bus request; completes as an error.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On mem_valid, latch addr/wdata/wstrb/route and go to REQ next cycle. The illegal case goes straight to DONE with an error.
  - req is driven from a register, so it first rises 1 cycle after mem_valid.
- REQ:
  - req_o held high with stable addr/we/be/wdata.
  - On gnt, req drops next cycle and the FSM goes to RESP.
  - rvalid seen in REQ is ignored (protocol violation).
- RESP:
  - On rvalid of the routed port, capture rdata (writes: mem_rdata=0) and err_i, then go to DONE.
  - rvalid on the other port is ignored.
- DONE:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - mem_rdata is held until the next completion.
- Best-case latency: mem_valid to mem_ready is 4 cycles (gnt in the first REQ cycle, rvalid in the cycle after gnt).
- Error handling: err_i=1 with rvalid gives mem_rdata=ERR_RDATA, err_o set, err_cnt_o+1 (saturates at 255). err_addr_o is loaded only if err_o was 0.
- Timeout:
  - A counter resets on IDLE exit and counts in REQ/RESP.
  - At TIMEOUT-1 the bridge aborts: req drops, the FSM goes to DONE with ERR_RDATA, and the error is recorded as above.
  - If the abort happens in RESP, the stale flag of that port is set.
  - The next rvalid on a stale port is discarded and clears the flag.
  - A new transaction to a stale port waits in REQ without asserting req until the flag clears. Time spent waiting still counts toward the timeout.
- err_clr_i in the same cycle as a new error: the set wins.
- mem_valid dropping mid-transaction: ignored; the transaction completes.
- Reset mid-operation: immediate return to IDLE; no mem_ready pulse.

Decomposition:
- Package mem_obi_pkg holds:
  - state enum (IDLE/REQ/RESP/DONE)
  - route enum (ROUTE_INSTR/ROUTE_DATA/ROUTE_ILLEGAL)
  - ERR_CNT_W=8
- One sub-module, mem_obi_err_log: sticky flag, first-error address and saturating counter.

Test Plan:
- Read 0x0000_0100, mem_instr=0: goes to the instruction port. gnt in cycle 1, rvalid with 0x1234_5678 a cycle later -> mem_ready pulse at cycle 4, mem_rdata=0x1234_5678, data_req_o never high.
- Write 0x2000_0004, wstrb=4'b0011, wdata=0xAABB_CCDD: gnt delayed 5 cycles -> data_req_o high 5 cycles with we=1, be=0011, then one mem_ready pulse.
- Read 0x2000_0000 with data_err_i=1 on rvalid -> mem_rdata=0xDEAD_BEEF, err_o=1, err_addr_o=0x2000_0000, err_cnt_o=1. A second error leaves err_addr_o unchanged. err_clr_i clears err_o; err_cnt_o stays at 2.
- TIMEOUT=16, gnt given, no rvalid -> mem_ready at timeout with ERR_RDATA. Late data rvalid is discarded. Next data read waits for that rvalid, then completes normally.
- Write with mem_instr=1 -> no req on either port, mem_ready 2 cycles after mem_valid, err_o=1.
- rst low while in RESP -> all outputs 0 asynchronously, no mem_ready. The next read after reset completes normally.
